hazard_stall_unit: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sits upstream of the forwarding unit and drives the write-enables and flushes of the PC, IF/ID and ID/EX registers that feed it. It handles three cases:
- load-use hazards, which forwarding cannot cover;
- taken-branch flushes;
- data-memory wait handshakes, with a timeout trap.

It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_unit.sv | 131 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller: load-use bubbles, branch flushes,
// data-memory wait freeze with timeout trap, stall perf counter.
module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             freeze,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nx;
    logic       pend_flush, pend_flush_nx;
    logic [7:0] wait_cnt, wait_cnt_nx;
    logic       err_nx;
    logic       mem_stall;
    logic       load_use;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_memread & (ex_rd != 5'd0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_nx      = state;
        pend_flush_nx = pend_flush;
        wait_cnt_nx   = wait_cnt;
        err_nx        = mem_timeout_err;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        freeze        = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    freeze        = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    state_nx      = MEM_WAIT;
                    wait_cnt_nx   = 8'd1;
                    pend_flush_nx = ex_branch_taken;
                end else if (ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    freeze        = 1'b1;
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    wait_cnt_nx   = wait_cnt + 8'd1;
                    pend_flush_nx = pend_flush | ex_branch_taken;
                    if (wait_cnt_nx >= TIMEOUT) begin
                        state_nx = TRAP;
                        err_nx   = 1'b1;
                    end
                end else begin
                    state_nx      = RUN;
                    wait_cnt_nx   = 8'd0;
                    pend_flush_nx = 1'b0;
                    if (pend_flush | ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
            end
            TRAP: begin
                freeze      = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end
            default: state_nx = RUN;
        endcase
        // Hold the strobes at their idle values while reset is asserted
        if (!rst_n) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            freeze       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            pend_flush      <= 1'b0;
            wait_cnt        <= 8'd0;
            mem_timeout_err <= 1'b0;
            stall_count     <= '0;
        end else begin
            state           <= state_nx;
            pend_flush      <= pend_flush_nx;
            wait_cnt        <= wait_cnt_nx;
            mem_timeout_err <= err_nx;
            if (!pc_write && stall_count != CNT_MAX)
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: vector table for single-cycle
// hazards plus sequences for memory wait, timeout and async reset.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_memread;
    logic       ex_branch_taken, mem_req, mem_ready;
    logic       pc_write, if_id_write, if_id_flush;
    logic       id_ex_bubble, freeze, mem_timeout_err;
    logic [3:0] stall_count;

    int tests = 0;
    int fails = 0;

    hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .freeze(freeze), .mem_timeout_err(mem_timeout_err),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [4:0] exp;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // exp order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze}
    task automatic chk_out(input string nm, input logic [4:0] exp);
        chk({nm, " strobes"},
            int'({pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze}),
            int'(exp));
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_memread = 0; ex_rd = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0};
        vecs[1] = '{"ld_use1",   5, 0, 1, 0, 1, 5, 0, 0, 0, 5'b00010, 1};
        vecs[2] = '{"ld_x0",     0, 0, 1, 0, 1, 0, 0, 0, 0, 5'b11000, 1};
        vecs[3] = '{"br_ldu",    5, 0, 1, 0, 1, 5, 1, 0, 0, 5'b11110, 1};
        vecs[4] = '{"ld_use2",   0, 7, 0, 1, 1, 7, 0, 0, 0, 5'b00010, 2};
        vecs[5] = '{"rs2_nouse", 0, 7, 0, 0, 1, 7, 0, 0, 0, 5'b11000, 2};
        vecs[6] = '{"no_load",   9, 0, 1, 0, 0, 9, 0, 0, 0, 5'b11000, 2};
        vecs[7] = '{"req_rdy",   0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11000, 2};
        vecs[8] = '{"rdy_only",  0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11000, 2};

        idle();
        rst_n = 1'b0;
        #12;
        chk_out("reset", 5'b11000);
        chk("reset cnt", int'(stall_count), 0);
        chk("reset err", int'(mem_timeout_err), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_memread = vecs[i].mr; ex_rd = vecs[i].rd;
            ex_branch_taken = vecs[i].br;
            mem_req = vecs[i].req; mem_ready = vecs[i].rdy;
            #1;
            chk_out(vecs[i].name, vecs[i].exp);
            @(posedge clk);
            #1;
            chk({vecs[i].name, " cnt"}, int'(stall_count), int'(vecs[i].cnt));
        end

        // Memory wait with a branch arriving mid-wait
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            mem_req = 1; mem_ready = 0;
            ex_branch_taken = (c == 2);
            #1;
            chk_out($sformatf("mw stall%0d", c), 5'b00001);
        end
        @(negedge clk);
        ex_branch_taken = 0; mem_ready = 1;
        #1;
        chk_out("mw ready", 5'b11110);
        @(negedge clk);
        idle();
        #1;
        chk_out("mw after", 5'b11000);
        chk("mw cnt", int'(stall_count), 3);

        // Three stalled cycles stay below the timeout; load-use on exit
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            mem_req = 1; mem_ready = 0;
        end
        @(negedge clk);
        mem_ready = 1; ex_memread = 1; ex_rd = 3;
        id_rs2 = 3; id_uses_rs2 = 1;
        #1;
        chk_out("nto ready ldu", 5'b00010);
        @(posedge clk);
        #1;
        chk("nto err", int'(mem_timeout_err), 0);
        chk("nto cnt", int'(stall_count), 4);

        // Timeout trap, sticky through mem_ready, counter saturates
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            mem_req = 1; mem_ready = 0;
            @(posedge clk);
            #1;
            chk($sformatf("to err%0d", c), int'(mem_timeout_err),
                (c == 4) ? 1 : 0);
        end
        @(negedge clk);
        mem_ready = 1; ex_branch_taken = 1;
        #1;
        chk_out("trap ready", 5'b00001);
        repeat (20) @(posedge clk);
        #1;
        chk("trap err", int'(mem_timeout_err), 1);
        chk("trap sat", int'(stall_count), 15);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("trap rst", 5'b11000);
        chk("trap rst err", int'(mem_timeout_err), 0);
        chk("trap rst cnt", int'(stall_count), 0);
        rst_n = 1'b1;

        // Async reset in the middle of a memory wait
        do_reset();
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            idle();
            mem_req = 1; mem_ready = 0;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 5'b11000);
        chk("arst cnt", int'(stall_count), 0);
        chk("arst err", int'(mem_timeout_err), 0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        chk_out("arst run", 5'b11000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
